mem_stage_hs: RTL

Parametrised next-generation memory pipeline stage with an integrated MEM/WB register. It sits between the EX/MEM register and write-back, and adds:
- byte, halfword, word and dword access with sign/zero-extended loads and byte-enabled stores
- a req/ack data-memory handshake with a variable number of wait states
- upstream stall, plus misalignment and ack-timeout error reporting.

Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_stage_hs.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - access-size codes, FSM state type and size helper for mem_stage_hs
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane shift and byte enables, load extract/extend, misalignment check
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          i_size,
  input  logic [LANE_W-1:0]   i_lane,
  input  logic                i_is_store,
  input  logic                i_unsigned,
  input  logic [DATA_W-1:0]   i_store_data,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata_ext,
  output logic                o_misalign
);

  localparam int NB = DATA_W / 8;

  logic [3:0]        w_bytes;
  logic [3:0]        w_lane4;
  logic [15:0]       w_be_mask;
  logic [15:0]       w_be_shift;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  assign w_bytes    = size_bytes(i_size);
  assign w_lane4    = 4'(i_lane);
  assign w_be_mask  = (16'd1 << w_bytes) - 16'd1;
  assign w_be_shift = w_be_mask << w_lane4;

  // A dword on a 32-bit datapath has no legal lane, so it is reported as misaligned.
  assign o_misalign = ((i_size == SZ_D) && (DATA_W == 32)) ||
                      ((w_lane4 & (w_bytes - 4'd1)) != 4'd0);

  assign o_be    = i_is_store ? w_be_shift[NB-1:0] : {NB{1'b1}};
  assign o_wdata = i_store_data << {i_lane, 3'b000};
  assign w_shift = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < NB; i++) begin
      w_keep[i*8 +: 8] = (i < int'(w_bytes)) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    w_sign = 1'b0;
    case (i_size)
      SZ_B:    w_sign = w_shift[7];
      SZ_H:    w_sign = w_shift[15];
      SZ_W:    w_sign = w_shift[31];
      default: w_sign = w_shift[DATA_W-1];
    endcase
    w_sign = w_sign & ~i_unsigned;
  end

  assign o_rdata_ext = (w_shift & w_keep) | ({DATA_W{w_sign}} & ~w_keep);

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - memory pipeline stage with req/ack data-memory handshake and MEM/WB register
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [REG_W-1:0]    ex_write_reg,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [1:0]          ex_size,
  input  logic                ex_unsigned,
  input  logic                ex_mem_to_reg,
  input  logic                ex_reg_write,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_alu_result,
  output logic [DATA_W-1:0]   wb_read_data,
  output logic [REG_W-1:0]    wb_write_reg,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write,
  output logic                wb_misalign,
  output logic                wb_bus_err
);

  localparam int LANE_W = $clog2(DATA_W / 8);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_mem_op;
  logic              w_lane_mis;
  logic              w_misalign;
  logic              w_req;
  logic              w_ack;
  logic              w_timeout;
  logic              w_err;
  logic              w_complete;
  logic [DATA_W-1:0] w_rdata_ext;

  mem_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .i_size       (ex_size),
    .i_lane       (ex_alu_result[LANE_W-1:0]),
    .i_is_store   (ex_mem_write),
    .i_unsigned   (ex_unsigned),
    .i_store_data (ex_store_data),
    .i_rdata      (dmem_rdata),
    .o_be         (dmem_be),
    .o_wdata      (dmem_wdata),
    .o_rdata_ext  (w_rdata_ext),
    .o_misalign   (w_lane_mis)
  );

  assign w_mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_misalign = w_mem_op & w_lane_mis;
  assign w_req      = w_mem_op & ~w_lane_mis;
  assign w_ack      = w_req & dmem_ack;
  assign w_timeout  = w_req & (r_state == WAIT) & (r_cnt == CNT_W'(TIMEOUT)) & ~dmem_ack;
  assign w_err      = w_misalign | w_timeout;
  assign w_complete = ex_valid & (~w_mem_op | w_misalign | w_ack | w_timeout);

  assign mem_stall = w_req & ~dmem_ack & ~w_timeout;
  // Request is masked by reset so it drops at once, even with ex_* still held upstream.
  assign dmem_req  = w_req & rst;
  assign dmem_we   = dmem_req & ex_mem_write;
  assign dmem_addr = ex_alu_result[ADDR_W+LANE_W-1:LANE_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !dmem_ack) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (!w_req || dmem_ack || w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_write_reg  <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_misalign   <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else if (w_complete) begin
      wb_valid      <= 1'b1;
      wb_alu_result <= ex_alu_result;
      wb_read_data  <= w_err ? '0 : w_rdata_ext;
      wb_write_reg  <= ex_write_reg;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_reg_write  <= ex_reg_write & ~w_err;
      wb_misalign   <= w_misalign;
      wb_bus_err    <= w_timeout;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end
  end

endmodule
